ifetch: RTL and testbench



---
 rtl/ifetch_pkg.sv | 24 ++
 rtl/ifetch_fifo.sv | 75 +++++++
 rtl/ifetch.sv | 101 ++++++++++
 tb/tb_ifetch.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// No logic; pure declarations.
// Imported by ifetch and ifetch_fifo.
package ifetch_pkg;

  localparam int unsigned ILEN = 32;

  // ADDI x0,x0,0: the decoder treats it as a no-op bubble.
  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

  localparam logic [ILEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered fetch: address of the word and the word itself.
  typedef struct packed {
    logic [ILEN-1:0] addr;
    logic [ILEN-1:0] data;
  } fetch_ent_t;

  // Instruction fetches are word aligned; the low two bits are cleared.
  function automatic logic [ILEN-1:0] word_align(input logic [ILEN-1:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO buffering fetched {addr, data} entries.
// Latency: a push is visible at the output the cycle after it is written.
// Backpressure: full_o reports no space; flush empties it and wins over push/pop.
module ifetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointers and occupancy; flush discards everything this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // The fetch issue rule keeps this FIFO from ever being pushed while full.
  always_ff @(posedge clk) begin
    if (!rst && push_i && !flush_i) assert (!full_o || pop_i);
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues word fetches, buffers responses for decode.
// Latency: kept response in cycle k is presented at k+1; redirect target at N+3 with 1-cycle memory.
// Backpressure: requests stop once buffered + outstanding would exceed DEPTH; ins held until popped.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_addr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] occ;
  logic          fifo_empty, fifo_full;
  fetch_ent_t    head, push_ent;
  logic          pop, accept, rsp, push;
  logic [CW:0]   inflight;

  // Presentation side: nothing is shown while in reset.
  assign ins_valid = !rst && !fifo_empty;
  assign pop       = ins_valid && ins_ready;
  assign ins       = ins_valid ? head.data : RV_NOP;
  assign ins_addr  = ins_valid ? head.addr : '0;

  // Issue rule: a slot freed by this cycle's pop may be reused immediately.
  assign inflight       = {1'b0, occ} + {1'b0, out_q} - {{CW{1'b0}}, pop};
  assign imem_req_valid = !rst && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses are kept only when no stale ones remain and no redirect is happening.
  assign rsp           = imem_rsp_valid && !rst;
  assign push          = rsp && (drop_q == '0) && !jump_en;
  assign push_ent.addr = rsp_pc_q;
  assign push_ent.data = imem_rsp_data;

  ifetch_fifo #(
    .WIDTH ($bits(fetch_ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop && !jump_en),
    .flush_i    (jump_en),
    .pop_dat_o  (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (occ)
  );

  // Next-state for PCs and counters; a redirect overrides everything else.
  always_comb begin
    out_d    = out_q + CW'(accept) - CW'(rsp);
    pc_d     = accept ? pc_q + 32'd4 : pc_q;
    rsp_pc_d = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
    drop_d   = (rsp && (drop_q != '0)) ? drop_q - CW'(1) : drop_q;
    if (jump_en) begin
      pc_d     = word_align(jump_addr);
      rsp_pc_d = word_align(jump_addr);
      // Everything still outstanding after this cycle belongs to the old path.
      drop_d   = out_d;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
  import ifetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int D = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_addr;

  ifetch #(.RESET_PC(RPC), .DEPTH(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .jump_en        (jump_en),
    .jump_addr      (jump_addr),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .ins_addr       (ins_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        jmp;
    logic [31:0] jaddr;
    int          lat;
    logic        rv;
    logic        ra_chk;
    logic [31:0] ra;
    logic        iv;
    logic [31:0] ia;
  } vec_t;

  vec_t        vecs [27];
  int          checks;
  int          errors;
  int          cyc;
  int          q_due [$];
  logic [31:0] q_addr [$];
  logic [31:0] exp_next;
  int          acc_cnt;
  int          pop_cnt;

  // Memory contents: each word is the bitwise inverse of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  function automatic vec_t mk(input logic r, input logic rd, input logic j,
                              input logic [31:0] ja, input int l,
                              input logic rv, input logic rc, input logic [31:0] ra,
                              input logic iv, input logic [31:0] ia);
    vec_t v;
    v.rst = r; v.rdy = rd; v.jmp = j; v.jaddr = ja; v.lat = l;
    v.rv = rv; v.ra_chk = rc; v.ra = ra; v.iv = iv; v.ia = ia;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, clock, advance memory model.
  task automatic run_row(input vec_t v, input int idx);
    logic        acc;
    logic        fired;
    logic [31:0] a_addr;
    rst       = v.rst;
    ins_ready = v.rdy;
    jump_en   = v.jmp;
    jump_addr = v.jaddr;
    #2;
    chk32($sformatf("c%0d req_valid", idx), {31'b0, imem_req_valid}, {31'b0, v.rv});
    if (v.ra_chk) chk32($sformatf("c%0d req_addr", idx), imem_req_addr, v.ra);
    chk32($sformatf("c%0d ins_valid", idx), {31'b0, ins_valid}, {31'b0, v.iv});
    chk32($sformatf("c%0d ins_addr", idx), ins_addr, v.iv ? v.ia : 32'h0);
    chk32($sformatf("c%0d ins", idx), ins, v.iv ? mem_word(v.ia) : 32'h0000_0013);
    // Stream model: every consumed instruction is the next in program order.
    if (!v.rst && !v.jmp && ins_valid && ins_ready) begin
      chk32($sformatf("c%0d stream_addr", idx), ins_addr, exp_next);
      chk32($sformatf("c%0d stream_data", idx), ins, mem_word(exp_next));
      exp_next = exp_next + 32'd4;
      pop_cnt++;
    end
    acc    = imem_req_valid && imem_req_ready;
    a_addr = imem_req_addr;
    fired  = imem_rsp_valid;
    if (acc) acc_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (v.rst) begin
      q_due.delete();
      q_addr.delete();
      exp_next = RPC;
      acc_cnt  = 0;
      pop_cnt  = 0;
    end else begin
      if (fired && q_due.size() > 0) begin
        void'(q_due.pop_front());
        void'(q_addr.pop_front());
      end
      if (acc) begin
        q_due.push_back(cyc - 1 + v.lat);
        q_addr.push_back(a_addr);
      end
      if (v.jmp) exp_next = v.jaddr & 32'hFFFF_FFFC;
    end
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(q_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    acc_cnt = 0; pop_cnt = 0; exp_next = RPC;
    rst = 1'b1; ins_ready = 1'b1; jump_en = 1'b0; jump_addr = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    //             rst rdy jmp jaddr         lat  rv ra? ra            iv ia
    vecs[0]  = mk(1, 1, 0, 32'h0,          1,  0, 0, 32'h0,         0, 32'h0);
    vecs[1]  = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h100,       0, 32'h0);
    vecs[2]  = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h104,       0, 32'h0);
    vecs[3]  = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h108,       1, 32'h100);
    vecs[4]  = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h10C,       1, 32'h104);
    vecs[5]  = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h110,       1, 32'h108);
    // Stall: FIFO fills, requests stop, visible instruction holds.
    vecs[6]  = mk(0, 0, 0, 32'h0,          1,  0, 0, 32'h0,         1, 32'h10C);
    vecs[7]  = mk(0, 0, 0, 32'h0,          1,  0, 0, 32'h0,         1, 32'h10C);
    vecs[8]  = mk(0, 0, 0, 32'h0,          1,  0, 0, 32'h0,         1, 32'h10C);
    vecs[9]  = mk(0, 0, 0, 32'h0,          1,  0, 0, 32'h0,         1, 32'h10C);
    vecs[10] = mk(0, 0, 0, 32'h0,          1,  0, 0, 32'h0,         1, 32'h10C);
    // Release: issue resumes in the same cycle.
    vecs[11] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h114,       1, 32'h10C);
    vecs[12] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h118,       1, 32'h110);
    vecs[13] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h11C,       1, 32'h114);
    // Jump coinciding with accept, response and pop.
    vecs[14] = mk(0, 1, 1, 32'h400,        1,  1, 1, 32'h120,       1, 32'h118);
    vecs[15] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h400,       0, 32'h0);
    vecs[16] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h404,       0, 32'h0);
    // Jump near the top of the address space; PC wraps.
    vecs[17] = mk(0, 1, 1, 32'hFFFF_FFF8,  1,  1, 1, 32'h408,       1, 32'h400);
    vecs[18] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'hFFFF_FFF8, 0, 32'h0);
    vecs[19] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'hFFFF_FFFC, 0, 32'h0);
    vecs[20] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h0,         1, 32'hFFFF_FFF8);
    vecs[21] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h4,         1, 32'hFFFF_FFFC);
    vecs[22] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h8,         1, 32'h0);
    // Reset mid-stream with a response in flight.
    vecs[23] = mk(1, 1, 0, 32'h0,          1,  0, 0, 32'h0,         0, 32'h0);
    vecs[24] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h100,       0, 32'h0);
    vecs[25] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h104,       0, 32'h0);
    vecs[26] = mk(0, 1, 0, 32'h0,          1,  1, 1, 32'h108,       1, 32'h100);

    for (int i = 0; i < 27; i++) begin
      run_row(vecs[i], i);
      if (i == 10) chk32("stall_inflight", acc_cnt - pop_cnt, D);
    end

    // 3-cycle memory, two requests outstanding, redirect to an unaligned target.
    run_row(mk(1, 1, 0, 32'h0,   3, 0, 0, 32'h0,   0, 32'h0),   27);
    run_row(mk(0, 1, 0, 32'h0,   3, 1, 1, 32'h100, 0, 32'h0),   28);
    run_row(mk(0, 1, 0, 32'h0,   3, 1, 1, 32'h104, 0, 32'h0),   29);
    run_row(mk(0, 1, 1, 32'h203, 3, 0, 0, 32'h0,   0, 32'h0),   30);
    run_row(mk(0, 1, 0, 32'h0,   3, 0, 1, 32'h200, 0, 32'h0),   31);
    run_row(mk(0, 1, 0, 32'h0,   3, 1, 1, 32'h200, 0, 32'h0),   32);
    run_row(mk(0, 1, 0, 32'h0,   3, 1, 1, 32'h204, 0, 32'h0),   33);
    run_row(mk(0, 1, 0, 32'h0,   3, 0, 0, 32'h0,   0, 32'h0),   34);
    run_row(mk(0, 1, 0, 32'h0,   3, 0, 0, 32'h0,   0, 32'h0),   35);
    run_row(mk(0, 1, 0, 32'h0,   3, 1, 1, 32'h208, 1, 32'h200), 36);
    run_row(mk(0, 1, 0, 32'h0,   3, 1, 1, 32'h20C, 1, 32'h204), 37);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
